// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file slice.
// Storage geometry lives here so decode, regfile and bench agree on widths.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_register_file_if.sv
// Register-file access bundle: two read index/data pairs plus the write-back port.
// master = decoder/write-back side, slave = register file.
interface mips_register_file_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
);

  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              signal_reg_write;

  modport master (
    output read_reg_1, read_reg_2, write_reg, write_data, signal_reg_write,
    input  read_data_1, read_data_2
  );

  modport slave (
    input  read_reg_1, read_reg_2, write_reg, write_data, signal_reg_write,
    output read_data_1, read_data_2
  );

endinterface

// File: rtl/mips_regfile_read_port.sv
// One combinational read port: index mux, register-0 masking, and (with
// MIPS_REGS_BYPASS_EN) same-cycle write-through forwarding.
module mips_regfile_read_port #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]               rd_idx_i,
`ifdef MIPS_REGS_BYPASS_EN
  input  logic                            rst_i,
  input  logic                            wr_en_i,
  input  logic [ADDR_W-1:0]               wr_idx_i,
  input  logic [DATA_W-1:0]               wr_dat_i,
`endif
  output logic [DATA_W-1:0]               rd_dat_o
);

  localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(mips_pkg::REG_ZERO);

`ifdef MIPS_REGS_BYPASS_EN
  logic fwd_hit;

  // Forwarding never applies to register 0 or while reset is clearing storage.
  assign fwd_hit = !rst_i && wr_en_i && (wr_idx_i != IDX_ZERO) && (wr_idx_i == rd_idx_i);
`endif

  always_comb begin
    rd_dat_o = regs_i[rd_idx_i];
    if (rd_idx_i == IDX_ZERO) begin
      rd_dat_o = '0;
    end
`ifdef MIPS_REGS_BYPASS_EN
    if (fwd_hit) begin
      rd_dat_o = wr_dat_i;
    end
`endif
  end

endmodule

// File: rtl/mips_register_file.sv
// 32x32 MIPS GPR file: two zero-latency read ports, one write port visible after the edge.
// Sync active-high reset clears all entries; MIPS_REGS_BYPASS_EN adds write-through reads.
module mips_register_file #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_register_file_if.slave  bus
);

  localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(mips_pkg::REG_ZERO);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (bus.signal_reg_write && (bus.write_reg != IDX_ZERO)) begin
      regs_d[bus.write_reg] = bus.write_data;
    end
    // Entry 0 is held at zero so it can never leak a stale value.
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  mips_regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_port_1 (
    .regs_i   (regs_q),
    .rd_idx_i (bus.read_reg_1),
`ifdef MIPS_REGS_BYPASS_EN
    .rst_i    (rst),
    .wr_en_i  (bus.signal_reg_write),
    .wr_idx_i (bus.write_reg),
    .wr_dat_i (bus.write_data),
`endif
    .rd_dat_o (bus.read_data_1)
  );

  mips_regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_port_2 (
    .regs_i   (regs_q),
    .rd_idx_i (bus.read_reg_2),
`ifdef MIPS_REGS_BYPASS_EN
    .rst_i    (rst),
    .wr_en_i  (bus.signal_reg_write),
    .wr_idx_i (bus.write_reg),
    .wr_dat_i (bus.write_data),
`endif
    .rd_dat_o (bus.read_data_2)
  );

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file; expected values are hand-computed constants.
module tb_mips_register_file;
  import mips_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mips_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mips_register_file #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.read_reg_1       = 5'd31;
    bus.read_reg_2       = 5'd30;
    bus.write_reg        = 5'd0;
    bus.write_data       = 32'h0;
    bus.signal_reg_write = 1'b0;

    // Reset
    tick();
    rst = 1'b0;
    #1;
    check("reset_rd1_r31", bus.read_data_1, 32'h0);
    check("reset_rd2_r30", bus.read_data_2, 32'h0);

    // Write disabled for 5 edges
    bus.write_reg  = 5'd30;
    bus.write_data = 32'hFF003FFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wr_dis_rd2_r30", bus.read_data_2, 32'h0);
      check("wr_dis_rd1_r31", bus.read_data_1, 32'h0);
    end

    // Write then read
    bus.signal_reg_write = 1'b1;
    tick();
    bus.signal_reg_write = 1'b0;
    #1;
    check("wr_rd2_r30", bus.read_data_2, 32'hFF003FFF);
    check("wr_rd1_r31", bus.read_data_1, 32'h0);

    // Second register, then both ports on the same index
    bus.write_reg        = 5'd31;
    bus.write_data       = 32'h0BADF00D;
    bus.signal_reg_write = 1'b1;
    tick();
    bus.signal_reg_write = 1'b0;
    #1;
    check("wr_rd1_r31_b", bus.read_data_1, 32'h0BADF00D);
    bus.read_reg_1 = 5'd30;
    #1;
    check("same_idx_rd1", bus.read_data_1, 32'hFF003FFF);
    check("same_idx_rd2", bus.read_data_2, 32'hFF003FFF);

    // Zero register: forwarding must not apply to index 0 either
    bus.write_reg        = 5'd0;
    bus.write_data       = 32'hDEADBEEF;
    bus.signal_reg_write = 1'b1;
    bus.read_reg_1       = 5'd0;
    bus.read_reg_2       = 5'd0;
    #1;
    check("r0_pre_rd1", bus.read_data_1, 32'h0);
    check("r0_pre_rd2", bus.read_data_2, 32'h0);
    tick();
    bus.signal_reg_write = 1'b0;
    #1;
    check("r0_post_rd1", bus.read_data_1, 32'h0);
    check("r0_post_rd2", bus.read_data_2, 32'h0);

    // Reset priority over a simultaneous write
    bus.write_reg        = 5'd5;
    bus.write_data       = 32'h00000055;
    bus.signal_reg_write = 1'b1;
    tick();
    bus.read_reg_1       = 5'd5;
    bus.read_reg_2       = 5'd30;
    bus.write_data       = 32'h12345678;
    rst                  = 1'b1;
    #1;
    check("rst_pri_pre_r5", bus.read_data_1, 32'h00000055);
    tick();
    rst                  = 1'b0;
    bus.signal_reg_write = 1'b0;
    #1;
    check("rst_pri_r5", bus.read_data_1, 32'h0);
    check("rst_pri_r30", bus.read_data_2, 32'h0);

    // Read-during-write on index 7; port 2 watches an unrelated index
    bus.write_reg        = 5'd7;
    bus.write_data       = 32'h00000001;
    bus.signal_reg_write = 1'b1;
    tick();
    bus.write_data = 32'hA5A5A5A5;
    bus.read_reg_1 = 5'd7;
    bus.read_reg_2 = 5'd6;
    #1;
`ifdef MIPS_REGS_BYPASS_EN
    check("rdw_pre_r7", bus.read_data_1, 32'hA5A5A5A5);
`else
    check("rdw_pre_r7", bus.read_data_1, 32'h00000001);
`endif
    check("rdw_pre_r6", bus.read_data_2, 32'h0);
    tick();
    bus.signal_reg_write = 1'b0;
    #1;
    check("rdw_post_r7", bus.read_data_1, 32'hA5A5A5A5);
    check("rdw_post_r6", bus.read_data_2, 32'h0);

    // Mid-program reset clears everything
    bus.read_reg_2 = 5'd7;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_rd1_r7", bus.read_data_1, 32'h0);
    check("mid_rst_rd2_r7", bus.read_data_2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
